seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode 8-digit seven-segment display. It sequences one shared hex-to-seven-segment decoder across all digits and drives one anode at a time with anti-ghost guard gaps. It double-buffers the displayed value so updates land only on frame boundaries, and it provides leading-zero suppression, per-digit blanking and decimal points. It sits between system logic (counters, status registers) and the board display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..8)
DIGIT_CYCLES, 100000, clock cycles per digit slot, guard included (>= GUARD_CYCLES+2)
GUARD_CYCLES, 1000, cycles at the start of each slot with all anodes off (>= 1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
value  in  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i]; digit 0 is rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
blank_in  in  NUM_DIGITS  force digit blank, active-high
lzs_en  in  1  leading-zero suppression enable
load  in  1  one-cycle strobe: capture value/dp_in/blank_in
an  out  NUM_DIGITS  anode enables, active-low
seg  out  8  cathodes, active-low; seg[0]=a .. seg[6]=g, seg[7]=dp
frame_tick  out  1  one-cycle pulse at each frame boundary
load_pending  out  1  high from load until the shadow update

Behaviour:
- Reset (async, immediate): an = all 1s, seg = 8'hFF, frame_tick = 0, load_pending = 0, slot counter = 0, digit index = 0, shadow value/dp/blank = 0, state = GUARD.
- Slot counter counts 0..DIGIT_CYCLES-1 and then wraps. The digit index advances on wrap, from NUM_DIGITS-1 back to 0.
- FSM states:
  - GUARD: counter < GUARD_CYCLES; an = all 1s, seg = 8'hFF.
  - DRIVE: remaining cycles of the slot; an[idx] = 0, all other anodes = 1.
  - Transition GUARD->DRIVE at counter == GUARD_CYCLES-1. Transition DRIVE->GUARD at slot wrap.
- In DRIVE, seg[6:0] = internal hex decoder output (active-low, 0-F glyphs) for shadow digit idx. seg[7] = ~shadow_dp[idx].
- Blanked digit: seg = 8'hFF, but the dp is still shown if requested. Digit is blanked if shadow_blank[idx] is set OR the digit is suppressed.
- Suppression (lzs_en=1): digit i is suppressed if all shadow digits j >= i equal 0. Digit 0 is never suppressed. lzs_en is sampled live, not shadowed.
- Outputs an/seg are registered and change only on clock edges, so they are glitch-free.
- Frame boundary: the cycle where idx = NUM_DIGITS-1 and the counter wraps. On this edge:
  - frame_tick = 1 for exactly that cycle.
  - If load_pending is set: shadow regs <= the captured regs and load_pending <= 0.
- load=1: value/dp_in/blank_in are captured into the holding regs on that edge, and load_pending <= 1.
- A new load while pending overwrites the holding regs; the latest wins.
- load coincident with the frame boundary: the new data is captured into the holding regs, the old pending data moves to the shadow regs, and load_pending stays 1.
- Latency: a load is visible no later than the next frame boundary plus GUARD_CYCLES+1 cycles.
- Reset mid-frame: outputs return to blank immediately; the pending load is discarded.

Optional Feature:
- Macro SEG_SCAN_BRIGHTNESS_EN.
- When defined: adds input bright [2:0]. Within DRIVE, the anode is enabled only while (counter - GUARD_CYCLES) < ((DIGIT_CYCLES-GUARD_CYCLES)*(bright+1))/8. For the rest of DRIVE, an = all 1s and seg = 8'hFF.
- bright is sampled at each slot start.
- When not defined: no bright port, and the anode stays on for all of DRIVE.

Test Plan:
All scenarios use NUM_DIGITS=4, DIGIT_CYCLES=8, GUARD_CYCLES=2.
- Reset then load value=16'h12A0, no blank/lzs -> per slot: cycles 0-1 an=4'hF, seg=FF; cycles 2-7 an=1110,1101,1011,0111 in successive slots; seg[6:0] = glyphs 0, A, 2, 1.
- Load 16'h0050, lzs_en=1 -> digits 3 and 2 blank (seg=FF, anode still low in DRIVE); digit 1 shows 5; digit 0 shows 0. Then value=0 -> only digit 0 shows 0.
- Load at mid-frame -> old digits shown until the frame_tick edge; load_pending=1 until then; new glyphs from digit 0 of the next frame.
- Two loads in one frame (0x1111, then 0x2222) -> only 0x2222 is ever displayed.
- dp_in=4'b0100, blank_in=4'b0100 -> digit 2 seg=8'h7F; others normal with seg[7]=1.
- Assert rst asynchronously during DRIVE -> an=F, seg=FF before the next clock edge; after release, the scan restarts at digit 0 with GUARD and shows 0000 glyphs (shadow cleared).

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Host/display bundle for seg_scan_ctrl. With SEG_SCAN_BRIGHTNESS_EN defined it
// also carries the 3-bit bright control.
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    lzs_en;
  logic                    load;
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [2:0]              bright;
`endif
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              seg;
  logic                    frame_tick;
  logic                    load_pending;
  // Debug view of the scan FSM: 1 while a digit slot is in DRIVE.
  logic                    scan_state;

  // Handshake: load is a one-cycle strobe sampled on the rising clock edge;
  // there is no ready, so every strobe is accepted and load_pending stays
  // high until the captured data reaches the display on a frame boundary.
`ifdef SEG_SCAN_BRIGHTNESS_EN
  modport master (
    output value, dp_in, blank_in, lzs_en, load, bright,
    input  an, seg, frame_tick, load_pending, scan_state
  );
  modport slave (
    input  value, dp_in, blank_in, lzs_en, load, bright,
    output an, seg, frame_tick, load_pending, scan_state
  );
`else
  modport master (
    output value, dp_in, blank_in, lzs_en, load,
    input  an, seg, frame_tick, load_pending, scan_state
  );
  modport slave (
    input  value, dp_in, blank_in, lzs_en, load,
    output an, seg, frame_tick, load_pending, scan_state
  );
`endif
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan controller with frame-aligned
// double buffering. Optional PWM brightness under SEG_SCAN_BRIGHTNESS_EN.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cnt_wrap, frame_edge, lit;

  logic [4*NUM_DIGITS-1:0] hold_value, shadow_value;
  logic [NUM_DIGITS-1:0]   hold_dp, hold_blank, shadow_dp, shadow_blank;
  logic                    pending_q;

  logic [NUM_DIGITS-1:0] digit_blank;
  logic                  upper_zero;
  logic [3:0]            cur_nibble;

  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            seg_q, seg_d;
  logic                  tick_q;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    logic [6:0] on;
    case (h)
      4'h0: on = 7'h3F;
      4'h1: on = 7'h06;
      4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;
      4'h4: on = 7'h66;
      4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;
      4'h7: on = 7'h07;
      4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      4'hA: on = 7'h77;
      4'hB: on = 7'h7C;
      4'hC: on = 7'h39;
      4'hD: on = 7'h5E;
      4'hE: on = 7'h79;
      default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  // A digit is suppressed when it and every digit above it are zero.
  always_comb begin
    upper_zero  = 1'b1;
    digit_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero     = upper_zero & (shadow_value[4*i +: 4] == 4'h0);
      digit_blank[i] = shadow_blank[i] | (bus.lzs_en & upper_zero & (i != 0));
    end
  end

`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [2:0] bright_q;
  int         on_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_q <= 3'd7;
    end else if (cnt_wrap) begin
      bright_q <= bus.bright;
    end
  end

  always_comb begin
    on_limit = ((DIGIT_CYCLES - GUARD_CYCLES) * (int'(bright_q) + 1)) / 8;
    lit      = (int'(cnt_d) - GUARD_CYCLES) < on_limit;
  end
`else
  assign lit = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_GUARD;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs are computed from the next counter/index so the registered
  // an/seg line up with the counter value of the same cycle.
  always_comb begin
    cnt_wrap   = (cnt_q == CNT_LAST);
    frame_edge = cnt_wrap && (idx_q == IDX_LAST);
    cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    state_d = state_q;
    case (state_q)
      S_GUARD: if (cnt_q == GUARD_LAST) state_d = S_DRIVE;
      S_DRIVE: if (cnt_wrap) state_d = S_GUARD;
      default: state_d = S_GUARD;
    endcase

    cur_nibble = shadow_value[{idx_d, 2'b00} +: 4];
    an_d       = '1;
    seg_d      = 8'hFF;
    if (state_d == S_DRIVE && lit) begin
      an_d[idx_d] = 1'b0;
      seg_d[7]    = ~shadow_dp[idx_d];
      seg_d[6:0]  = digit_blank[idx_d] ? 7'h7F : hex_glyph(cur_nibble);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q   <= '1;
      seg_q  <= 8'hFF;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      tick_q <= frame_edge;
    end
  end

  // A load on the boundary edge still captures; older pending data moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_value   <= '0;
      hold_dp      <= '0;
      hold_blank   <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      pending_q    <= 1'b0;
    end else begin
      if (frame_edge && pending_q) begin
        shadow_value <= hold_value;
        shadow_dp    <= hold_dp;
        shadow_blank <= hold_blank;
      end
      if (bus.load) begin
        hold_value <= bus.value;
        hold_dp    <= bus.dp_in;
        hold_blank <= bus.blank_in;
        pending_q  <= 1'b1;
      end else if (frame_edge) begin
        pending_q  <= 1'b0;
      end
    end
  end

  assign bus.an           = an_q;
  assign bus.seg          = seg_q;
  assign bus.frame_tick   = tick_q;
  assign bus.load_pending = pending_q;
  assign bus.scan_state   = (state_q == S_DRIVE);
endmodule
